// File: rtl/divider.sv
// Sequential 2N/N unsigned restoring divider with start/busy/done handshake.
// One quotient bit per clock; errors (divide-by-zero, quotient overflow) finish in one cycle.
module divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] D,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           dz,
  output logic           ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(N);

  logic [1:0]    state;
  logic [N:0]    rem;
  logic [N-1:0]  sh;
  logic [N-1:0]  bq;
  logic [CW-1:0] cnt;
  logic [N+1:0]  diff;
  logic          neg;
  logic [N:0]    rem_nx;
  logic [N-1:0]  sh_nx;
  logic          accept;

  // Trial subtraction is one bit wider than the partial remainder so its MSB is the borrow.
  always_comb begin
    diff   = {rem, sh[N-1]} - {2'b00, bq};
    neg    = diff[N+1];
    rem_nx = neg ? {rem[N-1:0], sh[N-1]} : diff[N:0];
    sh_nx  = {sh[N-2:0], ~neg};
  end

  assign accept = start && (state != CALC);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      rem   <= '0;
      sh    <= '0;
      bq    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      dz  <= 1'b0;
      ovf <= 1'b0;
      bq  <= B;
      if (B == '0) begin
        dz    <= 1'b1;
        ovf   <= 1'b1;
        Q     <= '1;
        R     <= D[N-1:0];
        state <= DONE;
      end else if (D[2*N-1:N] >= B) begin
        ovf   <= 1'b1;
        Q     <= '1;
        R     <= D[N-1:0];
        state <= DONE;
      end else begin
        rem   <= {1'b0, D[2*N-1:N]};
        sh    <= D[N-1:0];
        cnt   <= CW'(N-1);
        state <= CALC;
      end
    end else begin
      case (state)
        CALC: begin
          rem <= rem_nx;
          sh  <= sh_nx;
          if (cnt == '0) begin
            Q     <= sh_nx;
            R     <= rem_nx[N-1:0];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
# divider

Sequential 2N/N unsigned divider: the inverse of the datapath's combinational N×N `multiplier`. It divides a 2N-bit dividend (the width of a multiplier product) by an N-bit divisor. A restoring shift-subtract loop produces one quotient bit per clock. It returns an N-bit quotient and remainder under a start/busy/done handshake, and sits beside `multiplier` in the 16-bit CPU's execute stage.

## Interface
- `N`, 16, operand width; the dividend is 2N bits, quotient and remainder are N bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only while `busy`=0.
- `D`  in  2N  dividend, sampled with an accepted `start`.
- `B`  in  N  divisor, sampled with an accepted `start`.
- `Q`  out  N  quotient, registered.
- `R`  out  N  remainder, registered.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when results are valid.
- `dz`  out  1  divide-by-zero flag, valid with `done`.
- `ovf`  out  1  quotient-overflow flag, valid with `done`.

## Operation
- States are IDLE, CALC and DONE. Reset forces IDLE, and `Q`, `R`, `busy`, `done`, `dz` and `ovf` all become 0.
- **Accepting a start.** `start` is accepted on any edge where the state is IDLE or DONE. At that edge the block latches `D` and `B` and clears `dz` and `ovf`.
  - `start` is ignored while in CALC, with no queuing and no effect.
- **Error check at accept.**
  - If `B`==0: `dz`=1 and `ovf`=1.
  - Else if `D[2N-1:N]` >= `B`: `ovf`=1, because the quotient does not fit in N bits.
  - On either error, the next state is DONE, with `Q`={N{1}} and `R`=`D[N-1:0]`.
- **Normal path.** The next state is CALC. The remainder register `rem` is N+1 bits, initialised to {0,`D[2N-1:N]`}. The quotient/low-dividend shift register is loaded with `D[N-1:0]`.
- **Each CALC cycle**, for i = N-1 down to 0:
  - trial = {`rem`[N-1:0], dividend bit i} − {0,`B`}, computed at N+1 bits.
  - If trial is non-negative, `rem`=trial and quotient bit i=1. Otherwise `rem` is shifted in with no subtraction and quotient bit i=0.
  - Quotient bits shift into the register vacated by the consumed dividend bits.
  - The invariant `rem` < `B` holds throughout.
- **Leaving CALC.** After exactly N CALC cycles, the state moves to DONE. `Q` and `R` (=`rem[N-1:0]`) are written on that same edge.
- **DONE** lasts one cycle with `done`=1, then returns to IDLE unless a `start` is accepted.
- `Q`, `R`, `dz` and `ovf` hold their values until the next accepted `start` or `rst`.
- **Arithmetic.** Unsigned only. Results satisfy `D` = `Q`·`B` + `R` and `R` < `B` whenever `dz`=`ovf`=0.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled with `busy`=0.
- **Normal division.** `busy`=1 in cycles 1..N. In cycle N+1, `busy`=0, `done`=1 and `Q`/`R` are valid. Latency is N+1 cycles (17 at N=16).
- **Error case.** `busy` stays 0. In cycle 1, `done`=1 and the flags and outputs are valid.
- **Back-to-back operation.** A `start` in the DONE cycle is accepted. The next `busy` begins the following cycle, giving a throughput of one division per N+1 cycles.
- **`done` width.** `done` is exactly one cycle wide and is never high while `busy`=1.
- **Reset during CALC.** The operation is aborted at that edge: IDLE, all outputs 0, and no `done` pulse follows.
- **`rst` and `start` on the same edge.** `rst` wins and the `start` is dropped.
- **Inputs during CALC.** Changes to `D`/`B` have no effect on the operation in flight.

## Test plan
- **Basic division.** `D`=100, `B`=7, N=16: expect `busy` in cycles 1..16, then `done` in cycle 17 with `Q`=14, `R`=2, `dz`=`ovf`=0.
- **Full-width product.** `D`=0xFFFE0001, `B`=0xFFFF: expect `Q`=0xFFFF, `R`=0. Then run `D`=0xFFFEFFFF, `B`=0xFFFF: expect `Q`=0xFFFF, `R`=0xFFFE.
- **Errors.**
  - `B`=0, `D`=0x12345678: expect `done` in cycle 1, `dz`=`ovf`=1, `Q`=0xFFFF, `R`=0x5678, `busy` never high.
  - `D`=0x00010000, `B`=1: expect `ovf`=1, `dz`=0, same timing.
- **Handshake.**
  - Pulse `start` with new operands in cycle 5 of a busy operation: expect it ignored and the original result returned.
  - Assert `start` in the DONE cycle: expect a second result 17 cycles later.
- **Reset mid-operation.** Assert `rst` in cycle 8: expect all outputs 0 the next cycle, no `done` pulse, and a fresh `start` afterwards gives the correct result.
- **Random check.** At least 10k random (`D`,`B`) pairs with `D[31:16]` < `B`: check `D`==`Q`·`B`+`R` and `R`<`B`, and `done` exactly 17 cycles after each accept.
